pc_next_unit: RTL and testbench

Next-PC generator directly upstream of the PC register in the single-cycle CPU. It takes the current pc_addr plus decoded control-flow signals and combinationally produces pc_result, which the PC register loads on the next clk edge. It contains a small return-address stack (RAS): calls push their return address, returns pop it. This is the block's sequential state.

---
 rtl/pc_next_pkg.sv | 15 +
 rtl/ras_stack.sv | 109 ++++++++++
 rtl/pc_next_unit.sv | 93 +++++++++
 tb/tb_pc_next_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_next_pkg.sv
// Shared constants and the next-PC source encoding for the PC-next unit.
package pc_next_pkg;

    localparam int ADDR_W       = 32;
    localparam int INSN_INDEX_W = 26;

    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_RET,
        NPC_JMP,
        NPC_BR,
        NPC_SEQ
    } npc_sel_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with sticky overflow/underflow flags.
// With PC_NEXT_RAS_CHECK_EN defined it also keeps a sticky predicted-return mismatch flag.
module ras_stack #(
    parameter  int RAS_DEPTH = 4,
    parameter  int DATA_W    = pc_next_pkg::ADDR_W,
    localparam int PTR_W     = $clog2(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
`ifdef PC_NEXT_RAS_CHECK_EN
    input  logic              mismatch_set,
    output logic              mismatch,
`endif
    output logic [DATA_W-1:0] top,
    output logic [PTR_W:0]    count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);

    logic [DATA_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  wr_idx;
    logic              wr_en;
`ifdef PC_NEXT_RAS_CHECK_EN
    logic              mismatch_q, mismatch_d;
`endif

    assign top_idx = wp_q - PTR_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
        wp_d        = wp_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;
        wr_idx      = wp_q;
`ifdef PC_NEXT_RAS_CHECK_EN
        mismatch_d  = mismatch_q | mismatch_set;
`endif

        if (push && pop) begin
            // Call and return together replace the top; on an empty stack it degenerates to a push.
            wr_en = 1'b1;
            if (count_q == '0) begin
                wp_d    = wp_q + PTR_W'(1);
                count_d = (PTR_W+1)'(1);
            end else begin
                wr_idx = top_idx;
            end
        end else if (push) begin
            wr_en = 1'b1;
            wp_d  = wp_q + PTR_W'(1);
            if (count_q == FULL) overflow_d = 1'b1;
            else                 count_d    = count_q + (PTR_W+1)'(1);
        end else if (pop) begin
            if (count_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                wp_d    = top_idx;
                count_d = count_q - (PTR_W+1)'(1);
            end
        end

        if (!rstn) begin
            wp_d        = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
`ifdef PC_NEXT_RAS_CHECK_EN
            mismatch_d  = 1'b0;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        wp_q        <= wp_d;
        count_q     <= count_d;
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
`ifdef PC_NEXT_RAS_CHECK_EN
        mismatch_q  <= mismatch_d;
`endif
    end

    // NOTE: the entry storage is deliberately not reset; count gates every read, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= push_data;
    end

    assign top       = mem_q[top_idx];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`ifdef PC_NEXT_RAS_CHECK_EN
    assign mismatch  = mismatch_q;
`endif

endmodule

// File: rtl/pc_next_unit.sv
// Combinational next-PC selection (hold/return/jump/branch/sequential) with a return-address stack.
// Optional macro PC_NEXT_RAS_CHECK_EN adds return-target verification and the ras_mismatch output.
module pc_next_unit #(
    parameter  int ADDR_W    = pc_next_pkg::ADDR_W,
    parameter  int RAS_DEPTH = 4,
    localparam int PTR_W     = $clog2(RAS_DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [ADDR_W-1:0]                    pc_addr,
    input  logic                                 stall,
    input  logic                                 branch_taken,
    input  logic [ADDR_W-1:0]                    branch_offset,
    input  logic                                 jump,
    input  logic                                 call,
    input  logic                                 ret,
    input  logic [pc_next_pkg::INSN_INDEX_W-1:0] jump_index,
    input  logic [ADDR_W-1:0]                    jr_target,
    output logic [ADDR_W-1:0]                    pc_result,
`ifdef PC_NEXT_RAS_CHECK_EN
    output logic                                 ras_mismatch,
`endif
    output logic [PTR_W:0]                       ras_count,
    output logic                                 ras_overflow,
    output logic                                 ras_underflow
);

    import pc_next_pkg::*;

    npc_sel_t          sel;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] jmp_target;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] ret_target;
    logic [ADDR_W-1:0] pc_raw;
    logic              ras_valid;
    logic              ras_hit;

    assign pc_plus4   = pc_addr + ADDR_W'(4);
    assign br_target  = pc_plus4 + (branch_offset << 2);
    assign jmp_target = {pc_plus4[ADDR_W-1:INSN_INDEX_W+2], jump_index, 2'b00};
    assign ras_valid  = (ras_count != '0);

`ifdef PC_NEXT_RAS_CHECK_EN
    // A mispredicted return falls back to the register value, which is architecturally correct.
    assign ras_hit = ras_valid && (ras_top == jr_target);
`else
    assign ras_hit = ras_valid;
`endif
    assign ret_target = ras_hit ? ras_top : jr_target;

    always_comb begin
        sel = NPC_SEQ;
        if (stall)                  sel = NPC_HOLD;
        else if (ret)               sel = NPC_RET;
        else if (jump || call)      sel = NPC_JMP;
        else if (branch_taken)      sel = NPC_BR;
    end

    always_comb begin
        pc_raw = pc_plus4;
        unique case (sel)
            NPC_HOLD: pc_raw = pc_addr;
            NPC_RET:  pc_raw = ret_target;
            NPC_JMP:  pc_raw = jmp_target;
            NPC_BR:   pc_raw = br_target;
            default:  pc_raw = pc_plus4;
        endcase
    end

    assign pc_result = {pc_raw[ADDR_W-1:2], 2'b00};

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .DATA_W    (ADDR_W)
    ) u_ras (
        .clk          (clk),
        .rstn         (rstn),
        .push         (call && !stall),
        .pop          (ret && !stall),
        .push_data    (pc_plus4),
`ifdef PC_NEXT_RAS_CHECK_EN
        .mismatch_set (ret && !stall && ras_valid && (ras_top != jr_target)),
        .mismatch     (ras_mismatch),
`endif
        .top          (ras_top),
        .count        (ras_count),
        .overflow     (ras_overflow),
        .underflow    (ras_underflow)
    );

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios then random traffic against a queue-based model.
// Build with PC_NEXT_RAS_CHECK_EN defined to also exercise ras_mismatch.
module tb_pc_next_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pc_addr = '0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = '0;
    logic        jump = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [25:0] jump_index = '0;
    logic [31:0] jr_target = '0;
    logic [31:0] pc_result;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;
`ifdef PC_NEXT_RAS_CHECK_EN
    logic        ras_mismatch;
`endif

    pc_next_unit #(.ADDR_W(32), .RAS_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .pc_addr       (pc_addr),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .pc_result     (pc_result),
`ifdef PC_NEXT_RAS_CHECK_EN
        .ras_mismatch  (ras_mismatch),
`endif
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: return addresses as a queue, newest at the back.
    logic [31:0] ras_q[$];
    bit m_ovf = 0, m_unf = 0, m_mis = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_pc();
        logic [31:0] p4, r;
        bit use_top;
        p4 = pc_addr + 32'd4;
        if (stall) r = pc_addr;
        else if (ret) begin
            use_top = (ras_q.size() != 0);
`ifdef PC_NEXT_RAS_CHECK_EN
            if (use_top) use_top = (ras_q[ras_q.size()-1] == jr_target);
`endif
            r = use_top ? ras_q[ras_q.size()-1] : jr_target;
        end
        else if (jump || call) r = {p4[31:28], jump_index, 2'b00};
        else if (branch_taken) r = p4 + (branch_offset * 32'd4);
        else r = p4;
        return r & ~32'h3;
    endfunction

    function automatic void model_update();
        logic [31:0] p4;
        p4 = pc_addr + 32'd4;
        if (!rstn) begin
            ras_q.delete();
            m_ovf = 0; m_unf = 0; m_mis = 0;
        end else if (!stall) begin
`ifdef PC_NEXT_RAS_CHECK_EN
            if (ret && ras_q.size() != 0 && ras_q[ras_q.size()-1] != jr_target) m_mis = 1;
`endif
            if (call && ret) begin
                if (ras_q.size() != 0) ras_q[ras_q.size()-1] = p4;
                else ras_q.push_back(p4);
            end else if (call) begin
                if (ras_q.size() == DEPTH) begin
                    void'(ras_q.pop_front());
                    m_ovf = 1;
                end
                ras_q.push_back(p4);
            end else if (ret) begin
                if (ras_q.size() == 0) m_unf = 1;
                else void'(ras_q.pop_back());
            end
        end
    endfunction

    task automatic drive(input logic [31:0] pc, input logic st, input logic br, input logic [31:0] off,
                         input logic jp, input logic cl, input logic rt, input logic [25:0] idx,
                         input logic [31:0] jr);
        pc_addr = pc; stall = st; branch_taken = br; branch_offset = off;
        jump = jp; call = cl; ret = rt; jump_index = idx; jr_target = jr;
        #2;
    endtask

    // Checks the combinational result, clocks once, then checks the registered state.
    task automatic step(input string tag);
        check({tag, "/pc"}, pc_result, model_pc());
        @(posedge clk);
        model_update();
        #1;
        check({tag, "/cnt"}, 32'(ras_count), 32'(ras_q.size()));
        check({tag, "/ovf"}, 32'(ras_overflow), 32'(m_ovf));
        check({tag, "/unf"}, 32'(ras_underflow), 32'(m_unf));
`ifdef PC_NEXT_RAS_CHECK_EN
        check({tag, "/mis"}, 32'(ras_mismatch), 32'(m_mis));
`endif
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive(32'h0, 0, 0, 32'h0, 0, 0, 0, 26'h0, 32'h0);
        step("reset");
        rstn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        do_reset();
        check("rst_cnt", 32'(ras_count), 32'd0);
        check("rst_ovf", 32'(ras_overflow), 32'd0);
        check("rst_unf", 32'(ras_underflow), 32'd0);

        drive(32'h00400000, 0, 0, 32'h0, 0, 0, 0, 26'h0, 32'h0);
        check("seq_pc", pc_result, 32'h00400004);
        step("seq");

        drive(32'h00400010, 0, 1, 32'hFFFFFFFE, 0, 0, 0, 26'h0, 32'h0);
        check("br_back", pc_result, 32'h0040000C);
        step("br");
        drive(32'hFFFFFFFC, 0, 0, 32'h0, 0, 0, 0, 26'h0, 32'h0);
        check("seq_wrap", pc_result, 32'h00000000);
        step("wrap");

        drive(32'h00400020, 0, 0, 32'h0, 0, 1, 0, 26'h0100040, 32'h0);
        check("call_pc", pc_result, 32'h00400100);
        step("call");
        check("call_cnt", 32'(ras_count), 32'd1);
        drive(32'h00400100, 0, 0, 32'h0, 0, 0, 1, 26'h0, 32'hDEAD0000);
`ifndef PC_NEXT_RAS_CHECK_EN
        check("ret_pc", pc_result, 32'h00400024);
`endif
        step("ret");
        check("ret_cnt", 32'(ras_count), 32'd0);

        for (int i = 1; i <= 5; i++) begin
            drive(32'(i) << 8, 0, 0, 32'h0, 0, 1, 0, 26'h0, 32'h0);
            step("ovf_call");
        end
        check("ovf_flag", 32'(ras_overflow), 32'd1);
        check("ovf_cnt", 32'(ras_count), 32'd4);
        for (int i = 5; i >= 2; i--) begin
            drive(32'h0, 0, 0, 32'h0, 0, 0, 1, 26'h0, (32'(i) << 8) + 32'd4);
            check("ovf_ret", pc_result, (32'(i) << 8) + 32'd4);
            step("ovf_ret");
        end
        drive(32'h0, 0, 0, 32'h0, 0, 0, 1, 26'h0, 32'h12345678);
        check("unf_pc", pc_result, 32'h12345678);
        step("unf");
        check("unf_flag", 32'(ras_underflow), 32'd1);

        drive(32'h00000700, 1, 0, 32'h0, 0, 1, 0, 26'h3, 32'h0);
        check("stall_pc", pc_result, 32'h00000700);
        step("stall");
        check("stall_cnt", 32'(ras_count), 32'd0);

        drive(32'h100, 0, 0, 32'h0, 0, 1, 0, 26'h0, 32'h0); step("pair_a");
        drive(32'h200, 0, 0, 32'h0, 0, 1, 0, 26'h0, 32'h0); step("pair_b");
        drive(32'h300, 0, 0, 32'h0, 0, 1, 1, 26'h0, 32'h204);
        check("callret_pc", pc_result, 32'h204);
        step("callret");
        check("callret_cnt", 32'(ras_count), 32'd2);
        drive(32'h0, 0, 0, 32'h0, 0, 0, 1, 26'h0, 32'h304);
        check("callret_top", pc_result, 32'h304);
        step("callret_pop");

        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(32'(i) << 8, 0, 0, 32'h0, 0, 1, 0, 26'h0, 32'h0);
            step("mid_call");
        end
        rstn = 1'b0;
        drive(32'h400, 0, 0, 32'h0, 0, 1, 1, 26'h0, 32'h404);
        step("mid_rst");
        rstn = 1'b1;
        check("mid_cnt", 32'(ras_count), 32'd0);
        check("mid_ovf", 32'(ras_overflow), 32'd0);
        check("mid_unf", 32'(ras_underflow), 32'd0);
        drive(32'h0, 0, 0, 32'h0, 0, 0, 1, 26'h0, 32'h208);
        check("mid_ret", pc_result, 32'h208);
        step("mid_ret");

`ifdef PC_NEXT_RAS_CHECK_EN
        do_reset();
        drive(32'h100, 0, 0, 32'h0, 0, 1, 0, 26'h0, 32'h0); step("mis_call");
        drive(32'h0, 0, 0, 32'h0, 0, 0, 1, 26'h0, 32'h208);
        check("mis_pc", pc_result, 32'h208);
        step("mis_ret");
        check("mis_flag", 32'(ras_mismatch), 32'd1);
`endif

        for (int n = 0; n < 400; n++) begin
            logic [31:0] jr;
            int kind;
            rstn = ($urandom_range(0, 49) != 0);
            kind = $urandom_range(0, 9);
            jr = $urandom();
            if (ras_q.size() != 0 && $urandom_range(0, 1) == 1) jr = ras_q[ras_q.size()-1];
            drive($urandom(), ($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom(),
                  (kind == 0), (kind inside {1, 2, 3, 9}), (kind inside {4, 5, 6, 9}),
                  26'($urandom()), jr);
            step("rand");
        end
        rstn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
